// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
// Result is {remainder, quotient}; a zero divisor completes early with a flagged result.
module div_iter_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic                  annul_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  div_zero_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, DIVON, END} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*DATA_W-1:0]  result_q, result_d;
  logic                 ready_q, busy_q, dz_q, dz_d;

  logic [DATA_W-1:0]    dvd_raw_q, quot_q, rem_q, dvs_q;
  logic                 neg_quot_q, neg_rem_q;

  logic                 accept;
  logic [DATA_W:0]      trial;
  logic                 trial_ge;
  logic [DATA_W-1:0]    rem_nx, quot_nx;

  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic             is_signed);
    return (is_signed && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                   input logic             neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  assign accept = (state_q == IDLE) && start_i && !annul_i;

  // One restoring step: the difference always fits DATA_W bits when it is kept.
  always_comb begin
    trial    = {rem_q, quot_q[DATA_W-1]};
    trial_ge = (trial >= {1'b0, dvs_q});
    rem_nx   = trial_ge ? (trial[DATA_W-1:0] - dvs_q) : trial[DATA_W-1:0];
    quot_nx  = {quot_q[DATA_W-2:0], trial_ge};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    result_d = result_q;
    dz_d     = dz_q;
    case (state_q)
      IDLE: begin
        dz_d = 1'b0;
        if (accept) begin
          state_d = (opdata2_i == '0) ? DIVZERO : DIVON;
        end
      end
      DIVZERO: begin
        if (annul_i) begin
          state_d  = IDLE;
          result_d = '0;
          dz_d     = 1'b0;
        end else begin
          state_d  = END;
          result_d = {dvd_raw_q, {DATA_W{1'b1}}};
          dz_d     = 1'b1;
        end
      end
      DIVON: begin
        if (annul_i) begin
          state_d  = IDLE;
          result_d = '0;
          dz_d     = 1'b0;
        end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d  = END;
          result_d = {apply_sign(rem_nx, neg_rem_q), apply_sign(quot_nx, neg_quot_q)};
          dz_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      END: begin
        if (annul_i) begin
          state_d  = IDLE;
          result_d = '0;
          dz_d     = 1'b0;
        end else if (!start_i) begin
          state_d = IDLE;
          dz_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        dz_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= (state_d == END);
      busy_q   <= (state_d == DIVZERO) || (state_d == DIVON);
      dz_q     <= dz_d;
    end
  end

  // Operand registers are only meaningful after an acceptance, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_raw_q  <= opdata1_i;
      quot_q     <= magnitude(opdata1_i, signed_i);
      dvs_q      <= magnitude(opdata2_i, signed_i);
      rem_q      <= '0;
      neg_quot_q <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      neg_rem_q  <= signed_i & opdata1_i[DATA_W-1];
    end else if (state_q == DIVON) begin
      rem_q  <= rem_nx;
      quot_q <= quot_nx;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign div_zero_o = dz_q;

endmodule
